// File: rtl/register_file_pkg.sv
// Shared constants and types for the MIPS-style general-purpose register file.
package register_file_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/register_file_write_decoder.sv
// Turns a write address plus enable into a one-hot per-register write strobe.
module register_file_write_decoder #(
  parameter int unsigned ADDR_W   = register_file_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = register_file_pkg::NUM_REGS
) (
  input  logic [ADDR_W-1:0]   writeRegister,
  input  logic                regWrite,
  output logic [NUM_REGS-1:0] writeEn
);
  import register_file_pkg::*;

  always_comb begin
    writeEn = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      writeEn[i] = regWrite && (writeRegister == ADDR_W'(i));
    end
    // The zero register is hardwired, so it never takes a write.
    writeEn[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file; reads are combinational, writes commit on the rising edge.
module register_file #(
  parameter int unsigned DATA_W   = register_file_pkg::DATA_W,
  parameter int unsigned ADDR_W   = register_file_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = register_file_pkg::NUM_REGS
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);
  import register_file_pkg::*;

  logic [NUM_REGS-1:0] writeEn;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  register_file_write_decoder #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_write_decoder (
    .writeRegister(WriteRegister),
    .regWrite     (RegWrite),
    .writeEn      (writeEn)
  );

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        regs[g] <= '0;
      end else if (writeEn[g]) begin
        regs[g] <= WriteData;
      end
    end
  end

  // Address zero is forced to zero at the mux so the hardwired value never depends on storage.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadRegister1 != ADDR_W'(ZERO_REG)) ReadData1 = regs[ReadRegister1];
    if (ReadRegister2 != ADDR_W'(ZERO_REG)) ReadData2 = regs[ReadRegister2];
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table, corner sequences and random traffic.
module tb_register_file;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1, ReadData2;

  int checks = 0;
  int fails  = 0;
  logic [31:0] model [32];

  typedef struct {
    string       name;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [6];

  register_file dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .RegWrite     (RegWrite),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // One write transaction: drive after the falling edge, sample 1ns after the rising edge.
  task automatic writeCycle(input bit we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge Clk);
    RegWrite      = we;
    WriteRegister = wa;
    WriteData     = wd;
    @(posedge Clk);
    #1;
    if (we && wa != 0) model[wa] = wd;
    RegWrite = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [4:0] a1, input logic [4:0] a2);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    #1;
    check({name, "_p1"}, ReadData1, model[a1]);
    check({name, "_p2"}, ReadData2, model[a2]);
  endtask

  initial begin
    Rst_n = 1'b0;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    modelReset();

    vecs[0] = '{"write_r26",    1'b1, 5'd26, 32'h8000_007F, 5'd19, 5'd26, 32'h0,         32'h8000_007F};
    vecs[1] = '{"we_low_r19",   1'b0, 5'd19, 32'h8000_007F, 5'd19, 5'd26, 32'h0,         32'h8000_007F};
    vecs[2] = '{"write_r0",     1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0};
    vecs[3] = '{"write_r5",     1'b1, 5'd5,  32'h1234_5678, 5'd5,  5'd5,  32'h1234_5678, 32'h1234_5678};
    vecs[4] = '{"overwrite_r26",1'b1, 5'd26, 32'h0000_0001, 5'd26, 5'd5,  32'h0000_0001, 32'h1234_5678};
    vecs[5] = '{"we_low_r5",    1'b0, 5'd5,  32'hDEAD_0000, 5'd5,  5'd26, 32'h1234_5678, 32'h0000_0001};

    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Asynchronous reset asserted mid-cycle must clear outputs before any clock edge.
    writeCycle(1'b1, 5'd7, 32'hDEAD_BEEF);
    readCheck("pre_reset_r7", 5'd7, 5'd7);
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    modelReset();
    #1;
    check("async_reset_p1", ReadData1, 32'h0);
    check("async_reset_p2", ReadData2, 32'h0);
    for (int i = 0; i < 32; i++) begin
      readCheck("reset_sweep", 5'(i), 5'(31 - i));
    end
    // Writes while reset is held are ignored.
    writeCycle(1'b1, 5'd4, 32'h5555_AAAA);
    model[4] = '0;
    readCheck("write_in_reset", 5'd4, 5'd4);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      writeCycle(vecs[i].we, vecs[i].wa, vecs[i].wd);
      ReadRegister1 = vecs[i].ra1;
      ReadRegister2 = vecs[i].ra2;
      #1;
      check({vecs[i].name, "_p1"}, ReadData1, vecs[i].exp1);
      check({vecs[i].name, "_p2"}, ReadData2, vecs[i].exp2);
    end

    // Read-during-write: old value before the edge, new value right after it.
    @(negedge Clk);
    RegWrite = 1'b1;
    WriteRegister = 5'd9;
    WriteData = 32'hCAFE_F00D;
    ReadRegister1 = 5'd9;
    ReadRegister2 = 5'd9;
    #1;
    check("rdw_before_p1", ReadData1, 32'h0);
    check("rdw_before_p2", ReadData2, 32'h0);
    @(posedge Clk);
    #1;
    check("rdw_after_p1", ReadData1, 32'hCAFE_F00D);
    check("rdw_after_p2", ReadData2, 32'hCAFE_F00D);
    model[9] = 32'hCAFE_F00D;
    RegWrite = 1'b0;

    // Reset asserted on a writing edge: reset wins.
    @(negedge Clk);
    RegWrite = 1'b1;
    WriteRegister = 5'd3;
    WriteData = 32'h1111_2222;
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd9;
    @(posedge Clk);
    Rst_n = 1'b0;
    #1;
    check("reset_wins_r3", ReadData1, 32'h0);
    check("reset_wins_r9", ReadData2, 32'h0);
    modelReset();
    @(negedge Clk);
    RegWrite = 1'b0;
    Rst_n = 1'b1;

    // Full sweep with distinct addresses on each port.
    for (int i = 1; i < 32; i++) begin
      writeCycle(1'b1, 5'(i), 32'hA5A5_0000 | 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      readCheck("sweep", 5'(i), 5'((i + 13) % 32));
    end
    check("sweep_r31_const", model[31], 32'hA5A5_001F);

    // Random traffic against the array model, checking both sides of every edge.
    for (int n = 0; n < 300; n++) begin
      @(negedge Clk);
      RegWrite = 1'($urandom);
      WriteRegister = 5'($urandom);
      WriteData = $urandom;
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom);
      ReadRegister2 = 5'($urandom);
      #1;
      check("rand_pre_p1", ReadData1, model[ReadRegister1]);
      check("rand_pre_p2", ReadData2, model[ReadRegister2]);
      @(posedge Clk);
      #1;
      if (RegWrite && WriteRegister != 0) model[WriteRegister] = WriteData;
      check("rand_post_p1", ReadData1, model[ReadRegister1]);
      check("rand_post_p2", ReadData2, model[ReadRegister2]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
